battle_reveal: RTL

BATTLE_REVEAL -- requirements
Module: battle_reveal

---
 rtl/transition_pkg.sv | 12 +
 rtl/reveal_band.sv | 39 +++
 rtl/battle_reveal.sv | 129 ++++++++++++
 3 files changed

// File: rtl/transition_pkg.sv
// Shared geometry and state encoding for the battle-scene bar reveal.
package transition_pkg;

   localparam logic [10:0] X0        = 11'd431;
   localparam logic [7:0]  W         = 8'd165;
   localparam logic [10:0] Y0        = 11'd312;
   localparam int          BAND_H    = 24;
   localparam int          NUM_BANDS = 6;

   typedef enum logic [1:0] {IDLE, ARM, OPEN, DONE} state_t;

endpackage

// File: rtl/reveal_band.sv
// Covered flag for one horizontal band of the reveal window.
// Even bands open from the left edge, odd bands from the right edge.
module reveal_band
   import transition_pkg::*;
#(
   parameter int BAND = 0
) (
   input  logic [10:0] i_hcount,
   input  logic [9:0]  i_vcount,
   input  logic [7:0]  i_open,
   output logic        o_covered
);

   localparam logic [10:0] ROW_LO = Y0 + 11'(BAND * BAND_H);
   localparam logic [10:0] ROW_HI = ROW_LO + 11'(BAND_H);

   logic [10:0] w_vcount;
   logic [10:0] w_open;
   logic [10:0] w_col_lo;
   logic [10:0] w_col_hi;
   logic        w_in_rows;

   assign w_vcount  = {1'b0, i_vcount};
   assign w_open    = {3'b000, i_open};
   assign w_in_rows = (w_vcount >= ROW_LO) && (w_vcount < ROW_HI);

   generate
      if (BAND % 2 == 0) begin : g_even
         assign w_col_lo = X0 + w_open;
         assign w_col_hi = X0 + {3'b000, W};
      end else begin : g_odd
         assign w_col_lo = X0;
         assign w_col_hi = X0 + {3'b000, W} - w_open;
      end
   endgenerate

   assign o_covered = w_in_rows && (i_hcount >= w_col_lo) && (i_hcount < w_col_hi);

endmodule

// File: rtl/battle_reveal.sv
// Interleaved-bar reveal of the battle scene, opening STEP pixels per frame.
// Optional build macro REVEAL_FADE_EN dims uncovered scene pixels while the reveal runs.
//
// state | meaning
// IDLE  | waiting for start; window fully covered
// ARM   | start seen, waiting for the next frame tick
// OPEN  | opening advances once per frame tick
// DONE  | fully revealed; holds until start drops
module battle_reveal
   import transition_pkg::*;
#(
   parameter logic [11:0] BAR_COLOR = 12'h111,
   parameter int          STEP      = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic        start,
   input  logic [11:0] scene_pixel,
   output logic        busy,
   output logic        done,
   output logic [11:0] pixel_out
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [7:0]            r_open;
   logic [7:0]            w_open_nxt;
   logic [8:0]            w_open_sum;
   logic                  w_tick;
   logic [NUM_BANDS-1:0]  w_band_cov;
   logic                  w_covered;
   logic [11:0]           w_scene;
   logic [11:0]           r_pixel;

   assign w_tick     = (hcount == 11'd0) && (vcount == 10'd0);
   assign w_open_sum = {1'b0, r_open} + 9'(STEP);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= IDLE;
         r_open  <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_open  <= w_open_nxt;
      end
   end

   // Dropping start always wins over a coincident frame tick.
   always_comb begin
      w_state_nxt = r_state;
      w_open_nxt  = r_open;
      case (r_state)
         IDLE: begin
            w_open_nxt = 8'd0;
            if (start) w_state_nxt = ARM;
         end
         ARM: begin
            w_open_nxt = 8'd0;
            if (!start)      w_state_nxt = IDLE;
            else if (w_tick) w_state_nxt = OPEN;
         end
         OPEN: begin
            if (!start) begin
               w_state_nxt = IDLE;
               w_open_nxt  = 8'd0;
            end else if (w_tick) begin
               if (r_open == W)                w_state_nxt = DONE;
               else if (w_open_sum > {1'b0, W}) w_open_nxt  = W;
               else                            w_open_nxt  = w_open_sum[7:0];
            end
         end
         DONE: begin
            if (!start) begin
               w_state_nxt = IDLE;
               w_open_nxt  = 8'd0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_open_nxt  = 8'd0;
         end
      endcase
   end

   always_comb begin
      busy = (r_state == ARM) || (r_state == OPEN);
      done = (r_state == DONE);
   end

   generate
      for (genvar k = 0; k < NUM_BANDS; k++) begin : g_band
         reveal_band #(.BAND(k)) u_band (
            .i_hcount  (hcount),
            .i_vcount  (vcount),
            .i_open    (r_open),
            .o_covered (w_band_cov[k])
         );
      end
   endgenerate

   assign w_covered = (|w_band_cov) && (r_state != DONE);

`ifdef REVEAL_FADE_EN
   logic [1:0] w_shift;

   always_comb begin
      w_shift = 2'd0;
      if (busy) begin
         if (r_open < 8'd55)       w_shift = 2'd2;
         else if (r_open < 8'd110) w_shift = 2'd1;
      end
      w_scene = {scene_pixel[11:8] >> w_shift,
                 scene_pixel[7:4]  >> w_shift,
                 scene_pixel[3:0]  >> w_shift};
   end
`else
   assign w_scene = scene_pixel;
`endif

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) r_pixel <= 12'h000;
      else        r_pixel <= w_covered ? BAR_COLOR : w_scene;
   end

   assign pixel_out = r_pixel;

endmodule
